// File: rtl/trivium_stream_xor_if.sv
// Byte stream bundle between the data source, the XOR block and the downstream sink.
// The master drives din and accepts dout. The slave accepts din and produces dout.
interface trivium_stream_xor_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid
  );
endinterface

// File: rtl/trivium_stream_xor.sv
// Trivium keystream consumer. Prefetched keystream bytes are buffered in a FIFO.
// Each buffered byte is XORed with one byte of a start/len bounded message.
module trivium_stream_xor #(
  parameter int unsigned KS_DEPTH = 8,
  parameter int unsigned KS_SLACK = 2,
  parameter int unsigned LEN_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           i_ks_byte,
  input  logic                 i_ks_valid,
  output logic                 o_ks_enable,
  input  logic                 i_flush,
  input  logic                 i_start,
  input  logic [LEN_W-1:0]     i_len,
  trivium_stream_xor_if.slave  s_data,
  output logic [LEN_W-1:0]     o_byte_count,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_ks_overflow
);
  localparam int unsigned PtrW = $clog2(KS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [7:0]       r_mem [KS_DEPTH];
  logic [PtrW-1:0]  r_head, r_tail;
  logic [CntW-1:0]  r_count;
  logic [LEN_W-1:0] r_remaining, r_byte_count;
  logic [7:0]       r_dout;
  logic             r_dout_valid, r_overflow, r_ks_enable;

  logic             w_empty, w_full, w_din_ready, w_xfer, w_push, w_ks_enable_next;
  logic [CntW-1:0]  w_count_next, w_room;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CntW'(KS_DEPTH));
  // flush gates din_ready so an upstream byte is never reported as taken and then discarded
  assign w_din_ready = (r_state == StRun) && (r_remaining != '0) && !w_empty &&
                       (!r_dout_valid || s_data.dout_ready) && !i_flush;
  assign w_xfer = w_din_ready && s_data.din_valid;
  assign w_push = i_ks_valid && (!w_full || w_xfer);

  always_comb begin
    w_count_next = r_count;
    if (i_flush) begin
      w_count_next = '0;
    end else if (w_push && !w_xfer) begin
      w_count_next = r_count + CntW'(1);
    end else if (!w_push && w_xfer) begin
      w_count_next = r_count - CntW'(1);
    end
  end

  assign w_room           = CntW'(KS_DEPTH) - w_count_next;
  assign w_ks_enable_next = (w_room > CntW'(KS_SLACK));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= i_ks_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_remaining  <= '0;
      r_byte_count <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_ks_enable  <= 1'b0;
    end else if (i_flush) begin
      r_state      <= StIdle;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_ks_enable  <= w_ks_enable_next;
    end else begin
      r_count     <= w_count_next;
      r_ks_enable <= w_ks_enable_next;
      if (w_push) begin
        r_tail <= r_tail + PtrW'(1);
      end
      if (i_ks_valid && w_full && !w_xfer) begin
        r_overflow <= 1'b1;
      end
      if (w_xfer) begin
        r_head       <= r_head + PtrW'(1);
        r_dout       <= s_data.din ^ r_mem[r_head];
        r_dout_valid <= 1'b1;
        r_remaining  <= r_remaining - LEN_W'(1);
        r_byte_count <= r_byte_count + LEN_W'(1);
      end else if (s_data.dout_ready) begin
        r_dout_valid <= 1'b0;
      end
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_remaining  <= i_len;
            r_byte_count <= '0;
            r_state      <= (i_len == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          // leave only once the final byte has been taken downstream
          if (r_remaining == '0 && (!r_dout_valid || s_data.dout_ready)) begin
            r_state <= StDone;
          end
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ks_enable       = r_ks_enable;
  assign o_byte_count      = r_byte_count;
  assign o_busy            = (r_state != StIdle);
  assign o_done            = (r_state == StDone);
  assign o_ks_overflow     = r_overflow;
  assign s_data.din_ready  = w_din_ready;
  assign s_data.dout       = r_dout;
  assign s_data.dout_valid = r_dout_valid;
endmodule

// File: tb/tb_trivium_stream_xor.sv
// Self-checking bench for trivium_stream_xor: scenario tasks plus a keystream/output scoreboard.
module tb_trivium_stream_xor;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ks_byte;
  logic        ks_valid, ks_enable, flush, start;
  logic [15:0] len;
  logic [15:0] byte_count;
  logic        busy, done, ks_overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] ks_q[$];
  logic [7:0] exp_q[$];

  trivium_stream_xor_if s_if ();

  trivium_stream_xor #(.KS_DEPTH(8), .KS_SLACK(2), .LEN_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_ks_byte    (ks_byte),
    .i_ks_valid   (ks_valid),
    .o_ks_enable  (ks_enable),
    .i_flush      (flush),
    .i_start      (start),
    .i_len        (len),
    .s_data       (s_if),
    .o_byte_count (byte_count),
    .o_busy       (busy),
    .o_done       (done),
    .o_ks_overflow(ks_overflow)
  );

  always #5 clk = ~clk;

  // Scoreboard: model of the keystream FIFO; expected dout pushed at handshake, popped on accept.
  always @(negedge clk) begin
    logic xfer;
    logic [7:0] e;
    xfer = s_if.din_valid && s_if.din_ready;
    if (rst || flush) begin
      ks_q.delete();
      exp_q.delete();
    end else begin
      if (s_if.dout_valid && s_if.dout_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_dout: got %h with nothing expected", s_if.dout);
        end else begin
          e = exp_q.pop_front();
          if (s_if.dout !== e) begin
            n_bad++;
            $display("FAIL sb_dout: got %h want %h", s_if.dout, e);
          end
        end
      end
      if (xfer) begin
        n_cmp++;
        if (ks_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_ks: transfer accepted with model FIFO empty (got 1 want 0)");
        end else begin
          exp_q.push_back(s_if.din ^ ks_q.pop_front());
        end
      end
      if (ks_valid && (ks_q.size() < 8 || xfer)) ks_q.push_back(ks_byte);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ks(input logic [7:0] b);
    ks_byte = b;
    ks_valid = 1'b1;
    step();
    ks_valid = 1'b0;
  endtask

  task automatic start_msg(input logic [15:0] l);
    start = 1'b1;
    len = l;
    step();
    start = 1'b0;
  endtask

  // waited = cycles spent stalled before the handshake, -1 on timeout
  task automatic send_byte(input logic [7:0] d, output int waited);
    s_if.din = d;
    s_if.din_valid = 1'b1;
    waited = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (s_if.din_ready) begin
        step();
        s_if.din_valid = 1'b0;
        waited = i;
        return;
      end
      @(posedge clk);
      #1;
    end
    s_if.din_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        cyc = i;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if ({ks_enable, s_if.din_ready, s_if.dout_valid, done, busy, ks_overflow} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000000",
               {ks_enable, s_if.din_ready, s_if.dout_valid, done, busy, ks_overflow});
    end
    n_cmp++;
    if (s_if.dout !== 8'h00) begin
      n_bad++; $display("FAIL reset_dout: got %h want 00", s_if.dout);
    end
    n_cmp++;
    if (byte_count !== 16'd0) begin
      n_bad++; $display("FAIL reset_count: got %0d want 0", byte_count);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (ks_enable !== 1'b1) begin
      n_bad++; $display("FAIL reset_ks_enable: got %b want 1", ks_enable);
    end
  endtask

  task automatic test_prefetch();
    logic exp_en, exp_ov;
    int cnt;
    for (int i = 0; i < 12; i++) begin
      ks_byte = 8'(i);
      ks_valid = 1'b1;
      step();
      cnt = (i + 1 > 8) ? 8 : i + 1;
      exp_en = (cnt < 6);
      exp_ov = (i + 1 > 8);
      n_cmp++;
      if (ks_enable !== exp_en) begin
        n_bad++; $display("FAIL prefetch_enable[%0d]: got %b want %b", i, ks_enable, exp_en);
      end
      n_cmp++;
      if (ks_overflow !== exp_ov) begin
        n_bad++; $display("FAIL prefetch_overflow[%0d]: got %b want %b", i, ks_overflow, exp_ov);
      end
    end
    ks_valid = 1'b0;
  endtask

  // Zero plaintext exposes the buffered keystream 00..07 directly
  task automatic test_drain();
    int w;
    start_msg(16'd8);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h00, w);
      n_cmp++;
      if (w !== 0 || s_if.dout !== 8'(i)) begin
        n_bad++; $display("FAIL drain[%0d]: got dout %h wait %0d want %h wait 0", i, s_if.dout, w, 8'(i));
      end
    end
    wait_done(w);
    n_cmp++;
    if (w !== 1 || byte_count !== 16'd8) begin
      n_bad++; $display("FAIL drain_done: got delay %0d count %0d want 1 8", w, byte_count);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ks [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    logic [7:0] d  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] x  [4] = '{8'hB4, 8'h1E, 8'hCC, 8'h44};
    int w;
    for (int i = 0; i < 4; i++) push_ks(ks[i]);
    start_msg(16'd4);
    for (int i = 0; i < 4; i++) begin
      send_byte(d[i], w);
      n_cmp++;
      if (w !== 0 || s_if.dout !== x[i] || s_if.dout_valid !== 1'b1) begin
        n_bad++; $display("FAIL b2b[%0d]: got %h v%b wait %0d want %h v1 wait 0",
                          i, s_if.dout, s_if.dout_valid, w, x[i]);
      end
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL b2b_done_early: got %b want 0", done);
    end
    step();
    n_cmp++;
    if ({done, s_if.dout_valid} !== 2'b10 || byte_count !== 16'd4) begin
      n_bad++; $display("FAIL b2b_done: got done %b v %b count %0d want 1 0 4",
                        done, s_if.dout_valid, byte_count);
    end
    step();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_bad++; $display("FAIL b2b_idle: got %b want 00", {done, busy});
    end
  endtask

  task automatic test_stall();
    logic [7:0] ks [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    logic [7:0] d  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] x  [4] = '{8'hB4, 8'h1E, 8'hCC, 8'h44};
    int w;
    for (int i = 0; i < 4; i++) push_ks(ks[i]);
    start_msg(16'd4);
    send_byte(d[0], w);
    s_if.dout_ready = 1'b0;
    s_if.din = d[1];
    s_if.din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (s_if.din_ready !== 1'b0 || s_if.dout !== 8'hB4 || s_if.dout_valid !== 1'b1) begin
        n_bad++; $display("FAIL stall[%0d]: got rdy %b dout %h v %b want 0 b4 1",
                          i, s_if.din_ready, s_if.dout, s_if.dout_valid);
      end
      @(posedge clk);
      #1;
    end
    s_if.din_valid = 1'b0;
    s_if.dout_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      send_byte(d[i], w);
      n_cmp++;
      if (w !== 0 || s_if.dout !== x[i]) begin
        n_bad++; $display("FAIL stall_resume[%0d]: got %h wait %0d want %h wait 0", i, s_if.dout, w, x[i]);
      end
    end
    wait_done(w);
    n_cmp++;
    if (w !== 1 || byte_count !== 16'd4) begin
      n_bad++; $display("FAIL stall_done: got delay %0d count %0d want 1 4", w, byte_count);
    end
    step();
  endtask

  task automatic test_len_zero();
    int w;
    push_ks(8'h5A);
    start_msg(16'd0);
    n_cmp++;
    if ({done, busy, s_if.din_ready} !== 3'b110) begin
      n_bad++; $display("FAIL len0_done: got %b want 110", {done, busy, s_if.din_ready});
    end
    step();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_bad++; $display("FAIL len0_idle: got %b want 00", {done, busy});
    end
    // the untouched byte must still be at the FIFO head
    start_msg(16'd1);
    send_byte(8'h00, w);
    n_cmp++;
    if (w !== 0 || s_if.dout !== 8'h5A) begin
      n_bad++; $display("FAIL len0_kept: got %h wait %0d want 5a wait 0", s_if.dout, w);
    end
    wait_done(w);
    step();
  endtask

  task automatic test_empty_fifo();
    int w;
    start_msg(16'd1);
    s_if.din = 8'h0F;
    s_if.din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (s_if.din_ready !== 1'b0) begin
        n_bad++; $display("FAIL empty_ready[%0d]: got %b want 0", i, s_if.din_ready);
      end
      @(posedge clk);
      #1;
    end
    ks_byte = 8'h70;
    ks_valid = 1'b1;
    #1;
    n_cmp++;
    if (s_if.din_ready !== 1'b0) begin
      n_bad++; $display("FAIL empty_arrival_ready: got %b want 0", s_if.din_ready);
    end
    @(posedge clk);
    #1;
    ks_valid = 1'b0;
    #1;
    n_cmp++;
    if (s_if.din_ready !== 1'b1) begin
      n_bad++; $display("FAIL empty_next_ready: got %b want 1", s_if.din_ready);
    end
    @(posedge clk);
    #1;
    s_if.din_valid = 1'b0;
    n_cmp++;
    if (s_if.dout !== 8'h7F || s_if.dout_valid !== 1'b1) begin
      n_bad++; $display("FAIL empty_dout: got %h v %b want 7f v 1", s_if.dout, s_if.dout_valid);
    end
    wait_done(w);
    step();
  endtask

  task automatic test_flush();
    int w;
    n_cmp++;
    if (ks_overflow !== 1'b1) begin
      n_bad++; $display("FAIL flush_pre_overflow: got %b want 1", ks_overflow);
    end
    for (int i = 0; i < 5; i++) push_ks(8'h10 + 8'(i));
    start_msg(16'd5);
    send_byte(8'h01, w);
    send_byte(8'h02, w);
    n_cmp++;
    if (s_if.dout !== 8'h13) begin
      n_bad++; $display("FAIL flush_pre_dout: got %h want 13", s_if.dout);
    end
    flush = 1'b1;
    start = 1'b1;
    len = 16'd3;
    step();
    flush = 1'b0;
    start = 1'b0;
    n_cmp++;
    if ({busy, s_if.dout_valid, ks_overflow, done, ks_enable} !== 5'b00001) begin
      n_bad++; $display("FAIL flush_state: got %b want 00001",
                        {busy, s_if.dout_valid, ks_overflow, done, ks_enable});
    end
    start_msg(16'd1);
    s_if.din = 8'h55;
    s_if.din_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (s_if.din_ready !== 1'b0) begin
        n_bad++; $display("FAIL flush_empty[%0d]: got %b want 0", i, s_if.din_ready);
      end
      @(posedge clk);
      #1;
    end
    push_ks(8'hC3);
    send_byte(8'h55, w);
    n_cmp++;
    if (w !== 0 || s_if.dout !== 8'h96) begin
      n_bad++; $display("FAIL flush_new_msg: got %h wait %0d want 96 wait 0", s_if.dout, w);
    end
    wait_done(w);
    n_cmp++;
    if (w !== 1 || byte_count !== 16'd1) begin
      n_bad++; $display("FAIL flush_new_done: got delay %0d count %0d want 1 1", w, byte_count);
    end
    step();
  endtask

  initial begin
    rst = 1'b1;
    ks_byte = 8'h00;
    ks_valid = 1'b0;
    flush = 1'b0;
    start = 1'b0;
    len = 16'd0;
    s_if.din = 8'h00;
    s_if.din_valid = 1'b0;
    s_if.dout_ready = 1'b1;
    test_reset();
    test_prefetch();
    test_drain();
    test_back_to_back();
    test_stall();
    test_len_zero();
    test_empty_fifo();
    test_flush();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL sb_leftover: got %0d pending outputs want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
